// File: rtl/xt_pingpong_buf.sv
// Double-buffered x_t tile store: one bank loads while the other is read; banks swap on close/rd_done.
// Read latency 1 cycle; write backpressure via wr_ready, which drops while the write bank is still FULL.
module xt_pingpong_buf #(
  parameter int DATA_W    = 16,
  parameter int TILE_SIZE = 4,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [TILE_SIZE*DATA_W-1:0] wr_data,
  input  logic                        wr_last,
  output logic                        bank_ready,
  output logic [LEN_W-1:0]            bank_len,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_valid,
  output logic signed [DATA_W-1:0]    dout_vec [TILE_SIZE],
  input  logic                        rd_done,
  output logic                        ovf_err
);
  localparam int TW = TILE_SIZE * DATA_W;

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_st_t;

  bank_st_t          st  [2];
  logic [LEN_W-1:0]  len [2];
  logic              wb, rb;
  logic [ADDR_W-1:0] wptr;

  logic [TW-1:0]     mem [2*DEPTH];
  logic [TW-1:0]     rd_q;
  logic              rd_ok_q;

  logic wr_fire, wr_close, rd_legal, rd_release;

  assign wr_ready   = (st[wb] != BANK_FULL);
  assign wr_fire    = wr_valid && wr_ready;
  assign wr_close   = wr_fire && (wr_last || (wptr == ADDR_W'(DEPTH - 1)));
  assign bank_ready = (st[rb] == BANK_FULL);
  assign bank_len   = bank_ready ? len[rb] : '0;
  assign rd_legal   = rd_en && bank_ready && (LEN_W'(rd_addr) < len[rb]);
  assign rd_release = rd_done && bank_ready;

  // Write side only ever touches bank wb, read side only bank rb; a close needs
  // wb not FULL and a release needs rb FULL, so both can land in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]  <= BANK_EMPTY;
      st[1]  <= BANK_EMPTY;
      len[0] <= '0;
      len[1] <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wptr   <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_close) begin
          st[wb]  <= BANK_FULL;
          len[wb] <= LEN_W'(wptr) + LEN_W'(1);
          wb      <= ~wb;
          wptr    <= '0;
        end else begin
          st[wb]  <= BANK_FILLING;
          wptr    <= wptr + ADDR_W'(1);
        end
      end
      if (rd_release) begin
        st[rb]  <= BANK_EMPTY;
        len[rb] <= '0;
        rb      <= ~rb;
      end
    end
  end

  // Storage is never cleared, so a read issued alongside rd_done still returns its tile.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wb, wptr}] <= wr_data;
    if (rd_en)   rd_q <= mem[{rb, rd_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_ok_q  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_ok_q  <= rd_legal;
      if (rd_en && !rd_legal) ovf_err <= 1'b1;
    end
  end

  // Gate with the reset-cleared flag so no uninitialised array data escapes.
  always_comb begin
    for (int i = 0; i < TILE_SIZE; i++) begin
      dout_vec[i] = (rd_valid && rd_ok_q) ? signed'(rd_q[i*DATA_W +: DATA_W]) : '0;
    end
  end

endmodule

// File: tb/tb_xt_pingpong_buf.sv
// Directed bench for xt_pingpong_buf: fill/read, early close, full stall, streaming, release race, reset.
module tb_xt_pingpong_buf;
  localparam int DATA_W    = 16;
  localparam int TILE_SIZE = 4;
  localparam int DEPTH     = 64;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int LEN_W     = $clog2(DEPTH + 1);
  localparam int TW        = TILE_SIZE * DATA_W;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [TW-1:0]            wr_data;
  logic                     wr_last;
  logic                     bank_ready;
  logic [LEN_W-1:0]         bank_len;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_valid;
  logic signed [DATA_W-1:0] dout_vec [TILE_SIZE];
  logic                     rd_done;
  logic                     ovf_err;

  int checks = 0;
  int errors = 0;

  xt_pingpong_buf #(.DATA_W(DATA_W), .TILE_SIZE(TILE_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .bank_ready(bank_ready), .bank_len(bank_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .dout_vec(dout_vec),
    .rd_done(rd_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] tile(input int base, input int k);
    logic [TW-1:0] v;
    for (int i = 0; i < TILE_SIZE; i++) v[i*DATA_W +: DATA_W] = DATA_W'(base + 4*k + i);
    return v;
  endfunction

  function automatic logic [TW-1:0] dpack();
    logic [TW-1:0] v;
    for (int i = 0; i < TILE_SIZE; i++) v[i*DATA_W +: DATA_W] = dout_vec[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [TW-1:0] d, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    while (!wr_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!wr_ready) check("push_timeout", 64'(wr_ready), 64'd1);
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  // Leaves the bench at the negedge where the read result is visible.
  task automatic rd(input int addr, input logic done);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = ADDR_W'(addr); rd_done = done;
    @(negedge clk);
    rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic release_bank();
    @(negedge clk); rd_done = 1'b1;
    @(negedge clk); rd_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_bank_ready", 64'(bank_ready), 64'd0);
    check("rst_bank_len", 64'(bank_len), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_dout", dpack(), 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    rst_n = 1'b1;

    // Full 64-beat token closes on its own.
    for (int k = 0; k < 64; k++) push(tile(0, k), 1'b0);
    check("auto_bank_ready", 64'(bank_ready), 64'd1);
    check("auto_bank_len", 64'(bank_len), 64'd64);
    check("auto_wr_ready", 64'(wr_ready), 64'd1);
    rd(5, 1'b0);
    check("rd5_valid", 64'(rd_valid), 64'd1);
    check("rd5_dout", dpack(), {16'd23, 16'd22, 16'd21, 16'd20});
    check("rd5_ovf", 64'(ovf_err), 64'd0);
    rd(63, 1'b0);
    check("rd63_dout", dpack(), tile(0, 63));

    // 10-beat token closed by wr_last, then out-of-range read.
    for (int k = 0; k < 10; k++) push(tile(1000, k), k == 9);
    release_bank();
    check("len10_ready", 64'(bank_ready), 64'd1);
    check("len10_len", 64'(bank_len), 64'd10);
    rd(9, 1'b0);
    check("len10_rd9", dpack(), tile(1000, 9));
    rd(10, 1'b0);
    check("oor_valid", 64'(rd_valid), 64'd1);
    check("oor_dout", dpack(), 64'd0);
    check("oor_ovf", 64'(ovf_err), 64'd1);
    release_bank();
    check("empty_bank_ready", 64'(bank_ready), 64'd0);
    check("empty_bank_len", 64'(bank_len), 64'd0);

    // Both banks full: third token stalls until rd_done.
    for (int k = 0; k < 5; k++) push(tile(2000, k), k == 4);
    for (int k = 0; k < 64; k++) push(tile(3000, k), 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = tile(4000, 0); wr_last = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_wr_ready", 64'(wr_ready), 64'd0);
    check("stall_len", 64'(bank_len), 64'd5);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("unstall_wr_ready", 64'(wr_ready), 64'd1);
    check("unstall_bank_ready", 64'(bank_ready), 64'd1);
    check("unstall_len", 64'(bank_len), 64'd64);
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
    rd(63, 1'b0);
    check("bank1_rd63", dpack(), tile(3000, 63));
    release_bank();
    check("third_len", 64'(bank_len), 64'd1);
    rd(0, 1'b0);
    check("third_rd0", dpack(), tile(4000, 0));
    release_bank();

    // Streaming: 8 tokens of 16 tiles with wr_valid held high.
    fork
      begin : writer
        int n, g;
        logic acc;
        n = 0; g = 0;
        wr_valid = 1'b1; wr_data = tile(0, 0); wr_last = 1'b0;
        while (n < 128 && g < 5000) begin
          acc = wr_ready;
          @(negedge clk);
          g++;
          if (acc) begin
            n++;
            wr_data = tile((n / 16) * 100, n % 16);
            wr_last = ((n % 16) == 15);
          end
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        check("stream_beats", 64'(n), 64'd128);
      end
      begin : reader
        int g;
        for (int t = 0; t < 8; t++) begin
          g = 0;
          while (!bank_ready && g < 2000) begin
            @(negedge clk);
            g++;
          end
          if (!bank_ready) check("stream_wait", 64'(bank_ready), 64'd1);
          for (int j = 0; j < 16; j++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(j);
            @(negedge clk);
            check("stream_rd", dpack(), tile(t * 100, j));
          end
          rd_en = 1'b0; rd_done = 1'b1;
          @(negedge clk);
          rd_done = 1'b0;
        end
      end
    join
    check("stream_drained", 64'(bank_ready), 64'd0);

    // Read in the same cycle as rd_done returns the released bank's tile.
    for (int k = 0; k < 3; k++) push(tile(5000, k), k == 2);
    for (int k = 0; k < 3; k++) push(tile(6000, k), k == 2);
    rd(2, 1'b1);
    check("race_dout", dpack(), tile(5000, 2));
    check("race_next_ready", 64'(bank_ready), 64'd1);
    rd(2, 1'b0);
    check("race_next_dout", dpack(), tile(6000, 2));
    release_bank();

    // Reset mid-fill and mid-read.
    for (int k = 0; k < 4; k++) push(tile(7000, k), k == 3);
    for (int k = 0; k < 7; k++) push(tile(7500, k), 1'b0);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = ADDR_W'(1);
    @(posedge clk);
    #1;
    check("midrd_valid", 64'(rd_valid), 64'd1);
    check("midrd_dout", dpack(), tile(7000, 1));
    rst_n = 1'b0;
    #1;
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_dout", dpack(), 64'd0);
    check("arst_bank_ready", 64'(bank_ready), 64'd0);
    check("arst_bank_len", 64'(bank_len), 64'd0);
    check("arst_ovf", 64'(ovf_err), 64'd0);
    check("arst_wr_ready", 64'(wr_ready), 64'd1);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_bank_ready", 64'(bank_ready), 64'd0);
    check("post_wr_ready", 64'(wr_ready), 64'd1);
    check("post_ovf", 64'(ovf_err), 64'd0);
    push(tile(8000, 0), 1'b0);
    push(tile(8000, 1), 1'b1);
    check("post_len", 64'(bank_len), 64'd2);
    rd(1, 1'b0);
    check("post_rd1", dpack(), tile(8000, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/xt_pingpong_buf.md
Name: xt_pingpong_buf

Overview:
Writable, double-buffered successor to the static x_t ROM. An upstream loader streams x_t tiles into one bank while the controller reads the other bank with the same enable/address/one-cycle-latency tile read. Banks swap on explicit completion and release handshakes, so token t+1 loads while token t is consumed. The read side feeds the top-level xt_vec input directly.

Parameters:
DATA_W, 16, width of each signed element
TILE_SIZE, 4, elements per tile (one write beat, one read)
DEPTH, 64, tiles per bank
ADDR_W, $clog2(DEPTH), tile address width
LEN_W, $clog2(DEPTH+1), tile count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write beat valid
wr_ready  out  1  buffer can accept a beat
wr_data  in  TILE_SIZE*DATA_W  packed tile; element i at bits [i*DATA_W +: DATA_W]
wr_last  in  1  final beat of a token (closes the bank early)
bank_ready  out  1  current read bank is FULL
bank_len  out  LEN_W  tiles held in current read bank; 0 when !bank_ready
rd_en  in  1  read enable from controller
rd_addr  in  ADDR_W  tile address in read bank
rd_valid  out  1  dout_vec valid (rd_en delayed one cycle)
dout_vec  out  signed DATA_W x TILE_SIZE unpacked  read tile
rd_done  in  1  pulse: controller releases read bank
ovf_err  out  1  sticky: read issued out of range or with no ready bank

Behaviour:
- Storage: two banks of DEPTH x (TILE_SIZE*DATA_W). Per-bank state is EMPTY, FILLING, or FULL. Per-bank length register is LEN_W bits.
- Write bank pointer wb, read bank pointer rb. Both are 0 after reset.
- wr_ready = (state[wb] != FULL). A beat is accepted when wr_valid && wr_ready.
- On an accepted beat, data goes to bank wb at address wptr. wptr increments and state[wb] becomes FILLING.
- A bank closes when an accepted beat has wr_last=1, or when wptr==DEPTH-1. On close: len[wb]=wptr+1, state[wb]=FULL, wb toggles, wptr=0.
- An accepted beat never wraps within a bank. A beat arriving after an auto-close goes to the other bank, or stalls if that bank is FULL.
- bank_ready = (state[rb]==FULL). bank_len = len[rb] when bank_ready, else 0.
- Read, one-cycle latency:
  - A legal read is rd_en && bank_ready && rd_addr<len[rb]. It registers bank rb at rd_addr. The next cycle gives rd_valid=1 and dout_vec = that tile, little-endian: element 0 is the lowest DATA_W bits.
  - Any other rd_en: rd_valid=1 next cycle, dout_vec all zero, ovf_err set.
  - When rd_valid=0, dout_vec is all zero (no X propagation).
- rd_done with bank_ready sets state[rb]=EMPTY, len[rb]=0, and toggles rb. rd_done without bank_ready is ignored.
- A read in the same cycle as rd_done uses the pre-release bank. Its data still returns the next cycle, because the array is not cleared.
- Simultaneous close and rd_done on different banks: both take effect in that cycle. wr_ready recomputes from the new state next cycle.
- The two banks can never be the same bank in both FILLING and FULL. The write side only touches wb and the read side only touches rb.
- Reset (asynchronous assert, synchronous-style release):
  - Both banks EMPTY, lengths 0, wb=rb=0, wptr=0.
  - wr_ready=1, bank_ready=0, bank_len=0, rd_valid=0, dout_vec=0, ovf_err=0.
  - Array contents are not cleared.
  - Reset mid-fill or mid-read discards the token.
- ovf_err clears only on reset.

Test Plan:
- Reset, then load 64 beats of tile k = {4k+3,4k+2,4k+1,4k} with no wr_last -> auto-close, bank_ready=1, bank_len=64. Read addr 5 -> next cycle rd_valid=1, dout_vec = {20,21,22,23}.
- Write 10 beats with wr_last on beat 10 -> bank_len=10. Read addr 10 -> dout_vec = 0, ovf_err=1.
- Fill bank 0, begin filling bank 1, fill it completely, then offer a third token -> wr_ready=0 until rd_done. After rd_done: wr_ready=1 next cycle, bank_ready stays 1 (bank 1), and a read returns bank-1 data.
- Streaming: wr_valid held high while the reader does 16 reads plus rd_done per 16-tile token over 8 tokens -> every read matches its token's data, with no lost beats.
- rd_en and rd_done in the same cycle -> returned tile is from the released bank, and the next read comes from the other bank.
- Assert rst_n low mid-fill (beat 7) and mid-read -> all outputs zero the same cycle. After release: bank_ready=0, wr_ready=1, ovf_err=0.
